// File: rtl/axi_sram_slave.sv
// AXI slave memory responder backed by a word-addressed flop array.
// Services one burst at a time. When AW and AR both request in IDLE,
// the grant alternates, and the first tie after reset goes to read.
module axi_sram_slave #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DW     = 32,
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [3:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ID_W-1:0]   wid,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DW-1:0]     rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);

    localparam int OFF = $clog2(DW/8);
    localparam int SW  = DW/8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                prio_read_r;   // 1: read wins the next AW/AR tie
    logic [MEM_AW-1:0]   idx_r;         // word index of the current beat
    logic                fixed_r;
    logic [4:0]          cnt_r;         // beats left, including the current one
    logic                err_r;
    logic [DW-1:0]       mem [0:(1<<MEM_AW)-1];

    logic                grant_w_s;
    logic                grant_r_s;
    logic                aw_hs_s;
    logic                ar_hs_s;
    logic                w_hs_s;
    logic                b_hs_s;
    logic                r_hs_s;
    logic                last_beat_s;
    logic                beat_err_s;
    logic [MEM_AW-1:0]   aw_idx_s;
    logic [MEM_AW-1:0]   ar_idx_s;
    logic [MEM_AW-1:0]   next_idx_s;
    logic                unused_s;

    assign rresp    = 2'b00;
    assign unused_s = ^{awsize, arsize, wid, awaddr, araddr};

    // Arbitration, handshakes and index arithmetic.
    always_comb begin
        grant_w_s   = awvalid & (~arvalid | ~prio_read_r);
        grant_r_s   = arvalid & (~awvalid | prio_read_r);
        awready     = (state_r == IDLE) & grant_w_s;
        arready     = (state_r == IDLE) & grant_r_s;
        wready      = (state_r == WDATA);
        aw_hs_s     = awvalid & awready;
        ar_hs_s     = arvalid & arready;
        w_hs_s      = wvalid & wready;
        b_hs_s      = bvalid & bready;
        r_hs_s      = rvalid & rready;
        last_beat_s = (cnt_r == 5'd1);
        beat_err_s  = wlast ^ last_beat_s;
        aw_idx_s    = awaddr[MEM_AW+OFF-1:OFF];
        ar_idx_s    = araddr[MEM_AW+OFF-1:OFF];
        next_idx_s  = fixed_r ? idx_r : idx_r + MEM_AW'(1);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (aw_hs_s) begin
                    state_nxt_s = WDATA;
                end else if (ar_hs_s) begin
                    state_nxt_s = RDATA;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WDATA: begin
                if (w_hs_s && last_beat_s) begin
                    state_nxt_s = WRESP;
                end else begin
                    state_nxt_s = WDATA;
                end
            end
            WRESP: begin
                if (b_hs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WRESP;
                end
            end
            RDATA: begin
                if (r_hs_s && rlast) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RDATA;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Burst bookkeeping and registered B/R channel outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_read_r <= 1'b1;
            idx_r       <= '0;
            fixed_r     <= 1'b0;
            cnt_r       <= 5'd0;
            err_r       <= 1'b0;
            bid         <= '0;
            bresp       <= 2'b00;
            bvalid      <= 1'b0;
            rid         <= '0;
            rdata       <= '0;
            rlast       <= 1'b0;
            rvalid      <= 1'b0;
        end else if (aw_hs_s) begin
            bid         <= awid;
            idx_r       <= aw_idx_s;
            fixed_r     <= (awburst == 2'b00);
            cnt_r       <= {1'b0, awlen} + 5'd1;
            err_r       <= 1'b0;
            prio_read_r <= 1'b1;
        end else if (ar_hs_s) begin
            rid         <= arid;
            idx_r       <= ar_idx_s;
            fixed_r     <= (arburst == 2'b00);
            cnt_r       <= {1'b0, arlen} + 5'd1;
            rdata       <= mem[ar_idx_s];
            rlast       <= (arlen == 4'd0);
            rvalid      <= 1'b1;
            prio_read_r <= 1'b0;
        end else if (w_hs_s) begin
            idx_r <= next_idx_s;
            cnt_r <= cnt_r - 5'd1;
            if (beat_err_s) begin
                err_r <= 1'b1;
            end
            if (last_beat_s) begin
                bvalid <= 1'b1;
                bresp  <= (err_r | beat_err_s) ? 2'b10 : 2'b00;
            end
        end else if (b_hs_s) begin
            bvalid <= 1'b0;
        end else if (r_hs_s) begin
            if (rlast) begin
                rvalid <= 1'b0;
            end else begin
                idx_r <= next_idx_s;
                cnt_r <= cnt_r - 5'd1;
                rdata <= mem[next_idx_s];
                rlast <= (cnt_r == 5'd2);
            end
        end
    end

    // Byte-strobed array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_hs_s) begin
            for (int b = 0; b < SW; b++) begin
                if (wstrb[b]) begin
                    mem[idx_r][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: table-driven single-beat vectors,
// scoreboard-checked bursts, and hand-written multi-cycle corner cases.
module tb_axi_sram_slave;

    localparam int ID_W = 4, ADDR_W = 32, DW = 32, MEM_AW = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ID_W-1:0]   awid, wid, bid, arid, rid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [3:0]        awlen, arlen;
    logic [2:0]        awsize, arsize;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]     wdata, rdata;
    logic [DW/8-1:0]   wstrb;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } rbeat_t;
    rbeat_t sb[$];

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[6];

    logic [31:0] q[$];

    axi_sram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DW(DW), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push_rd(input logic [31:0] d, input logic l);
        rbeat_t e;
        e.d = d;
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [31:0] d[$], input logic [3:0] strb,
                            input int bad, input logic [1:0] exp_resp, input int hold);
        int t;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        #1;
        t = 0;
        while (!awready && t < 50) begin
            @(negedge clk); #1; t++;
        end
        chk("aw_accept", awready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = d[b]; wstrb = strb; wlast = (b == int'(len)) || (b == bad); wvalid = 1'b1;
            #1;
            chk("wready", wready, 1'b1);
            chk("no_early_b", bvalid, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_lat", bvalid, 1'b1);
        chk("bid", bid, id);
        chk("bresp", bresp, exp_resp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("b_hold_valid", bvalid, 1'b1);
            chk("b_hold_id", bid, id);
            chk("b_hold_resp", bresp, exp_resp);
        end
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        chk("b_done", bvalid, 1'b0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input bit toggle);
        int t;
        logic [31:0] hd;
        logic hl;
        bit stalled;
        rbeat_t e;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        #1;
        t = 0;
        while (!arready && t < 50) begin
            @(negedge clk); #1; t++;
        end
        chk("ar_accept", arready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        chk("rvalid_lat", rvalid, 1'b1);
        t = 0;
        stalled = 1'b0;
        hd = '0;
        hl = 1'b0;
        while (sb.size() > 0 && t < 200) begin
            rready = !toggle || (t % 2 == 1);
            #1;
            if (rvalid) begin
                if (stalled) begin
                    chk("r_hold_data", rdata, hd);
                    chk("r_hold_last", rlast, hl);
                end
                if (rready) begin
                    e = sb.pop_front();
                    chk("rdata", rdata, e.d);
                    chk("rlast", rlast, e.l);
                    chk("rid", rid, id);
                    stalled = 1'b0;
                end else begin
                    hd = rdata;
                    hl = rlast;
                    stalled = 1'b1;
                end
            end
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        rready = 1'b0;
        chk("r_drain", sb.size(), 0);
        chk("r_done", rvalid, 1'b0);
        sb.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF};
        tbl[1] = '{32'h0000_0300, 32'hAABB_CCDD, 4'hF, 32'h0000_0300, 32'hAABB_CCDD};
        tbl[2] = '{32'h0000_0300, 32'h1122_3344, 4'h5, 32'h0000_0300, 32'hAA22_CC44};
        tbl[3] = '{32'h0000_1003, 32'h1234_5678, 4'hF, 32'h0000_0000, 32'h1234_5678};
        tbl[4] = '{32'h0000_0300, 32'h5566_7788, 4'hA, 32'h0000_0300, 32'h5522_7744};
        tbl[5] = '{32'h0000_0304, 32'h0BAD_F00D, 4'hF, 32'h0000_0306, 32'h0BAD_F00D};

        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bid", bid, 4'h0);
        chk("rst_rid", rid, 4'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rlast", rlast, 1'b0);
        rst_n = 1'b1;

        // Single-beat write/read vectors with constant expectations.
        for (int i = 0; i < 6; i++) begin
            q.delete();
            q.push_back(tbl[i].wdata);
            do_write(4'(i), tbl[i].waddr, 4'd0, 2'b01, q, tbl[i].wstrb, -1, 2'b00, 0);
            push_rd(tbl[i].exp, 1'b1);
            do_read(4'(i + 8), tbl[i].raddr, 4'd0, 2'b01, 1'b0);
        end

        // INCR burst with B held off for 5 cycles, then back-to-back read.
        q.delete();
        for (int i = 1; i <= 4; i++) q.push_back(32'(i));
        do_write(4'd3, 32'h100, 4'd3, 2'b01, q, 4'hF, -1, 2'b00, 5);
        for (int i = 1; i <= 4; i++) push_rd(32'(i), i == 4);
        do_read(4'd5, 32'h100, 4'd3, 2'b01, 1'b0);
        // Same burst with rready toggling.
        for (int i = 1; i <= 4; i++) push_rd(32'(i), i == 4);
        do_read(4'd6, 32'h100, 4'd3, 2'b01, 1'b1);

        // FIXED burst overwrites one word.
        q.delete();
        q.push_back(32'd5); q.push_back(32'd6); q.push_back(32'd7);
        do_write(4'd7, 32'h20, 4'd2, 2'b00, q, 4'hF, -1, 2'b00, 0);
        push_rd(32'd7, 1'b1);
        do_read(4'd7, 32'h20, 4'd0, 2'b01, 1'b0);
        push_rd(32'd7, 1'b0); push_rd(32'd7, 1'b1);
        do_read(4'd2, 32'h20, 4'd1, 2'b00, 1'b0);

        // INCR from the last word wraps to index 0.
        q.delete();
        q.push_back(32'hA0A0_A0A0); q.push_back(32'hB1B1_B1B1);
        do_write(4'd1, 32'hFFC, 4'd1, 2'b01, q, 4'hF, -1, 2'b00, 0);
        push_rd(32'hA0A0_A0A0, 1'b0); push_rd(32'hB1B1_B1B1, 1'b1);
        do_read(4'd1, 32'hFFC, 4'd1, 2'b01, 1'b0);
        push_rd(32'hB1B1_B1B1, 1'b1);
        do_read(4'd1, 32'h0, 4'd0, 2'b01, 1'b0);

        // Early wlast: all four beats still land, response is SLVERR.
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(32'h10 + 32'(i));
        do_write(4'd4, 32'h200, 4'd3, 2'b01, q, 4'hF, 1, 2'b10, 0);
        for (int i = 0; i < 4; i++) push_rd(32'h10 + 32'(i), i == 3);
        do_read(4'd4, 32'h200, 4'd3, 2'b01, 1'b0);

        // Reserved burst encoding behaves as INCR.
        q.delete();
        q.push_back(32'hC0DE_0001); q.push_back(32'hC0DE_0002);
        do_write(4'd2, 32'h280, 4'd1, 2'b11, q, 4'hF, -1, 2'b00, 0);
        push_rd(32'hC0DE_0001, 1'b0); push_rd(32'hC0DE_0002, 1'b1);
        do_read(4'd2, 32'h280, 4'd1, 2'b01, 1'b0);

        // Reset, then simultaneous AW and AR: read first, write second.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        awid = 4'd9; awaddr = 32'h500; awlen = 4'd0; awburst = 2'b01; awvalid = 1'b1;
        arid = 4'd6; araddr = 32'h40; arlen = 4'd0; arburst = 2'b01; arvalid = 1'b1;
        #1;
        chk("arb_first_ar", arready, 1'b1);
        chk("arb_first_aw", awready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        #1;
        chk("arb_rvalid", rvalid, 1'b1);
        chk("arb_rdata_kept", rdata, 32'hDEAD_BEEF);
        chk("arb_rid", rid, 4'd6);
        chk("arb_aw_blocked", awready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        #1;
        chk("arb_r_done", rvalid, 1'b0);
        chk("arb_second_aw", awready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0;
        chk("arb_bvalid", bvalid, 1'b1);
        chk("arb_bid", bid, 4'd9);
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        // Last grant was write, so a tie now goes to read.
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("arb_alt_ar", arready, 1'b1);
        chk("arb_alt_aw", awready, 1'b0);
        awvalid = 1'b0; arvalid = 1'b0;
        push_rd(32'h5A5A_5A5A, 1'b1);
        do_read(4'd3, 32'h500, 4'd0, 2'b01, 1'b0);

        // Reset in the middle of a read burst.
        @(negedge clk);
        arid = 4'd5; araddr = 32'h100; arlen = 4'd3; arburst = 2'b01; arvalid = 1'b1;
        #1;
        chk("mid_ar_accept", arready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        chk("mid_rvalid", rvalid, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_rvalid", rvalid, 1'b0);
        chk("mid_rst_rdata", rdata, 32'h0);
        awvalid = 1'b1;
        #1;
        chk("mid_rst_idle", awready, 1'b1);
        awvalid = 1'b0;
        push_rd(32'd1, 1'b1);
        do_read(4'd0, 32'h100, 4'd0, 2'b01, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI slave memory responder: the target end of the AXI master port that the matrix engine's DMA drives.
- Accepts AW/W/B and AR/R bursts and services them from an internal word-addressed flop array.
- Used as the system-memory model in block and top-level benches, and as a small on-chip scratch memory.
- Handles one transaction at a time; reads and writes are arbitrated.

Parameters:
- ID_W, 4, AXI ID width
- ADDR_W, 32, AXI address width
- DW, 32, AXI data width (power of two, ≥32)
- MEM_AW, 10, log2 of memory depth in DW-bit words

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- awid  in  ID_W  write ID
- awaddr  in  ADDR_W  write start byte address
- awlen  in  4  beats-1
- awsize  in  3  ignored (full-width beats assumed)
- awburst  in  2  00 FIXED, 01 INCR, others treated as INCR
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wid  in  ID_W  ignored
- wdata  in  DW  write data
- wstrb  in  DW/8  byte strobes
- wlast  in  1  last write beat
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  ID_W  response ID
- bresp  out  2  00 OKAY, 10 SLVERR
- bvalid  out  1  B valid
- bready  in  1  B ready
- arid, araddr, arlen, arsize, arburst, arvalid  in  ID_W/ADDR_W/4/3/2/1  read address channel, same semantics as AW
- arready  out  1  AR ready
- rid  out  ID_W  read ID
- rdata  out  DW  read data
- rresp  out  2  always 00
- rlast  out  1  last read beat
- rvalid  out  1  R valid
- rready  in  1  R ready

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, priority bit=read; all ready/valid outputs 0; bid, rid, rdata, bresp, rlast = 0. Memory contents are not reset.
- Reset mid-burst abandons the transaction; no B or R is issued for it.
- Word index = addr[MEM_AW+log2(DW/8)-1 : log2(DW/8)]. Higher address bits are ignored (modulo wrap). Low bits are ignored (unaligned addresses are aligned down).
- INCR: index+1 per beat, wrapping mod 2^MEM_AW. FIXED: index constant.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE arbitration:
  - Only awvalid → grant write; only arvalid → grant read.
  - Both valid → grant the side opposite the previous grant; the first grant after reset goes to read.
- awready = (IDLE & write granted); arready = (IDLE & read granted). Both are combinational from registered state and the valids, and are never high together.
- AW handshake:
  - Latch id, index, burst, beat count = awlen+1; clear error flag; go to WDATA.
- WDATA:
  - wready=1.
  - Each wvalid beat writes the bytes where wstrb=1 at the current index, then advances the index.
  - Error flag set if wlast=1 on a non-final beat, or wlast=0 on the final beat.
  - Burst ends after awlen+1 beats regardless of wlast; go to WRESP.
- WRESP:
  - bvalid=1, bid=latched id, bresp = error ? 10 : 00. Outputs are held stable until bready.
  - On handshake: bvalid→0, go to IDLE.
  - Earliest next AW/AR acceptance is the cycle after the B handshake.
- AR handshake:
  - Latch id and burst; load rdata ← mem[index] registered; rvalid=1 next cycle in RDATA.
  - rlast = (arlen==0).
- RDATA:
  - rvalid, rdata, rid, rlast are held stable until rready.
  - On handshake with rlast=0: rdata ← mem[next index], remaining beats decremented, rvalid stays 1. Back-to-back beats give one beat per cycle.
  - On handshake with rlast=1: rvalid→0, go to IDLE.
- Latency: AR handshake to first rvalid = 1 cycle. Final W handshake to bvalid = 1 cycle.
- A read returns data committed by any write whose B has completed. There is no overlap, so no hazard.
- awsize/arsize and wid are not checked.

Test Plan:
- Reset then single write: awaddr=0x40, awlen=0, wdata=0xDEADBEEF, wstrb=F, wlast=1 → bvalid one cycle after W handshake, bresp=00, bid=awid. Then read araddr=0x40, arlen=0 → rdata=0xDEADBEEF, rlast=1, rvalid one cycle after AR handshake.
- INCR burst: write awlen=3 at 0x100 with 1,2,3,4 → read arlen=3 at 0x100 returns 1,2,3,4 back-to-back with rready=1, rlast only on beat 4.
- Strobes and FIXED: write 0xAABBCCDD, then write 0x11223344 with wstrb=0101 → read 0xAA22CC44. FIXED write awlen=2 of 5,6,7 at 0x20 → read 7.
- Backpressure and wrap: rready toggled every other cycle → rdata/rlast stable while stalled. bready held 0 for 5 cycles → bvalid, bid, bresp stable. INCR burst starting at the last word wraps to index 0.
- Protocol errors: wlast=1 on beat 2 of awlen=3 → 4 beats still consumed, bresp=10. AW and AR asserted in the same cycle after reset → read granted first, write second. Reset asserted mid-read burst → rvalid=0 next cycle, state IDLE.
